// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame arbiter and its byte producers.
package uart_tx_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Frame header byte; the host resynchronises on it after an aborted frame.
    localparam logic [7:0] UART_SOF = 8'hF0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic logic is_sof(input logic [7:0] b);
        return b == UART_SOF;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer byte streams and UART TX FIFO write port shared through the arbiter.
interface uart_tx_arbiter_if
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    fifo_full;
    logic [7:0]              fifo_dout;
    logic                    fifo_wr_en;

    // Environment side: producers plus the FIFO's almost-full flag.
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_dout, fifo_wr_en
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_dout, fifo_wr_en
    );

endinterface

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo N.
module rr_arb_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan the farthest candidate first so the nearest one after ptr wins.
        for (int off = N; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing the UART TX FIFO write port,
// with a watchdog that revokes the grant from a producer stalled mid-frame.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                frame_done,
    output logic                abort
);

    localparam int              CNT_W       = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  RR_INIT     = ID_W'(NUM_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [7:0]       dout_q, dout_d;
    logic             wr_en_q, wr_en_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             grant_valid;
    logic             grant_last;
    logic [7:0]       grant_data;
    logic             accept;

    rr_arb_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_valid = bus.req_valid[grant_q];
    assign grant_last  = bus.req_last[grant_q];
    assign grant_data  = bus.req_data[grant_q];
    assign accept      = (state_q == ST_BUSY) && grant_valid && !bus.fifo_full;

    always_comb begin
        bus.req_ready          = '0;
        bus.req_ready[grant_q] = accept;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;
        dout_d   = dout_q;
        wr_en_d  = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (accept) begin
                    dout_d  = grant_data;
                    wr_en_d = 1'b1;
                    stall_d = '0;
                    if (grant_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q;
                        done_d   = 1'b1;
                    end
                end else if (!grant_valid) begin
                    // Only a silent grantee ages the watchdog; a full FIFO does not.
                    if (stall_q == STALL_LIMIT) begin
                        abort_d  = 1'b1;
                        rr_ptr_d = grant_q;
                        stall_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= RR_INIT;
            stall_q  <= '0;
            dout_q   <= 8'h00;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
            dout_q   <= dout_d;
            wr_en_q  <= wr_en_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.fifo_dout  = dout_q;
    assign bus.fifo_wr_en = wr_en_q;
    assign busy           = (state_q == ST_BUSY);
    assign grant_id       = grant_q;
    assign frame_done     = done_q;
    assign abort          = abort_q;

endmodule
